devtbl_walker: RTL

- Initiator on the pi1 device-table interface. On request, it walks the table entry by entry and sums the map sizes to locate a device by id.
- It returns that device's byte base address, map size and interrupt flag.
- It sits beside the boot/loader logic, drives a pi1 master port into the interconnect, and is the host-side counterpart of the device-table responder.

---
 rtl/devtbl_walker_pkg.sv | 35 +++
 rtl/devtbl_walker_if.sv | 21 ++
 rtl/devtbl_walker_pi1_rdreq.sv | 42 ++++
 rtl/devtbl_walker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/devtbl_walker_pkg.sv
// rtl/devtbl_walker_pkg.sv - shared constants, op codes and state type for the device-table walker
package devtbl_walker_pkg;

  localparam int ARCHBITSZ = 32;
  localparam int ADDRBITSZ = 30;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi_op_e;

  localparam logic [ARCHBITSZ-1:0] DEVID_RAM    = 32'd1;
  localparam logic [ARCHBITSZ-1:0] DEVID_TINY   = 32'd3;
  localparam logic [ARCHBITSZ-1:0] DEVID_BLKDEV = 32'd4;
  localparam logic [ARCHBITSZ-1:0] DEVID_TINY2  = 32'd5;
  localparam logic [ARCHBITSZ-1:0] DEVID_DEVTBL = 32'd7;

  // Flag bits in the low two bits of the size word
  localparam int FLAG_INTR_BIT = 0;
  localparam int FLAG_RSVD_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VER_REQ,
    ST_VER_WAIT,
    ST_RDID_REQ,
    ST_RDID_WAIT,
    ST_RDSZ_REQ,
    ST_RDSZ_WAIT,
    ST_DONE
  } walk_state_e;

endpackage

// File: rtl/devtbl_walker_if.sv
// rtl/devtbl_walker_if.sv - pi1 bus bundle with master/slave views
interface devtbl_walker_if;
  import devtbl_walker_pkg::*;

  logic [1:0]           pi1_op;
  logic [ADDRBITSZ-1:0] pi1_addr;
  logic [ARCHBITSZ-1:0] pi1_data_w;
  logic [3:0]           pi1_sel;
  logic [ARCHBITSZ-1:0] pi1_data_r;
  logic                 pi1_rdy;

  modport master (
    output pi1_op, pi1_addr, pi1_data_w, pi1_sel,
    input  pi1_data_r, pi1_rdy
  );

  modport slave (
    input  pi1_op, pi1_addr, pi1_data_w, pi1_sel,
    output pi1_data_r, pi1_rdy
  );
endinterface

// File: rtl/devtbl_walker_pi1_rdreq.sv
// rtl/devtbl_walker_pi1_rdreq.sv - one pi1 request/capture handshake
module devtbl_walker_pi1_rdreq
  import devtbl_walker_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [ADDRBITSZ-1:0] i_addr,
  output logic                 o_acc,
  output logic                 o_done,
  output logic [ARCHBITSZ-1:0] o_data,
  devtbl_walker_if.master      pi1
);

  logic r_wait;
  logic w_issue;

  // The request is driven straight from the caller while it holds i_start,
  // so op/addr stay stable until the responder accepts it.
  assign w_issue        = i_start && !r_wait;
  assign pi1.pi1_op     = w_issue ? i_op : PINOOP;
  assign pi1.pi1_addr   = w_issue ? i_addr : '0;
  assign pi1.pi1_data_w = '0;
  assign pi1.pi1_sel    = 4'hF;

  assign o_acc  = w_issue && pi1.pi1_rdy;
  assign o_done = r_wait && pi1.pi1_rdy;
  assign o_data = pi1.pi1_data_r;

  // Track whether an accepted request is still waiting for its data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait <= 1'b0;
    end else if (o_acc) begin
      r_wait <= 1'b1;
    end else if (o_done) begin
      r_wait <= 1'b0;
    end
  end

endmodule

// File: rtl/devtbl_walker.sv
// rtl/devtbl_walker.sv - walks the device table to find a device; DEVTBL_WALKER_VERSION_EN adds version_o
module devtbl_walker
  import devtbl_walker_pkg::*;
#(
  parameter logic [ADDRBITSZ-1:0] DEVTBLADDR   = 30'h380,
  parameter logic [ARCHBITSZ-1:0] DEVSPACEBASE = 32'h0,
  parameter int                   MAXENTRIES   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 find_i,
  input  logic [ARCHBITSZ-1:0] id_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 found_o,
  output logic [ARCHBITSZ-1:0] base_o,
  output logic [ADDRBITSZ-1:0] mapsz_o,
  output logic                 intr_o,
`ifdef DEVTBL_WALKER_VERSION_EN
  output logic [ARCHBITSZ-1:0] version_o,
`endif
  devtbl_walker_if.master      pi1
);

  localparam int KW = $clog2(MAXENTRIES + 1);
  localparam logic [KW-1:0] KMAX = KW'(MAXENTRIES);

  walk_state_e          r_state, w_next;
  logic [ARCHBITSZ-1:0] r_id, r_cur_id, r_base_acc, r_base;
  logic [ADDRBITSZ-1:0] r_mapsz;
  logic [KW-1:0]        r_k;
  logic                 r_found, r_intr;
  logic [KW-1:0]        w_k_inc;
  logic [ADDRBITSZ-1:0] w_k_word;
  logic                 w_start, w_acc, w_done;
  pi_op_e               w_op;
  logic [ADDRBITSZ-1:0] w_addr;
  logic [ARCHBITSZ-1:0] w_data;
`ifdef DEVTBL_WALKER_VERSION_EN
  logic [ARCHBITSZ-1:0] r_version;
  assign version_o = r_version;
`endif

  assign w_k_inc  = r_k + 1'b1;
  assign w_k_word = ADDRBITSZ'({r_k, 1'b0});

  devtbl_walker_pi1_rdreq u_rdreq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_start (w_start),
    .i_op    (w_op),
    .i_addr  (w_addr),
    .o_acc   (w_acc),
    .o_done  (w_done),
    .o_data  (w_data),
    .pi1     (pi1)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and the request presented to the handshake helper
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_op    = PIRDOP;
    w_addr  = DEVTBLADDR + w_k_word;
    case (r_state)
      ST_IDLE: begin
`ifdef DEVTBL_WALKER_VERSION_EN
        if (find_i) w_next = ST_VER_REQ;
`else
        if (find_i) w_next = ST_RDID_REQ;
`endif
      end
      ST_VER_REQ: begin
        w_start = 1'b1;
        w_op    = PIRWOP;
        w_addr  = DEVTBLADDR;
        if (w_acc) w_next = ST_VER_WAIT;
      end
      ST_VER_WAIT:  if (w_done) w_next = ST_RDID_REQ;
      ST_RDID_REQ: begin
        w_start = 1'b1;
        if (w_acc) w_next = ST_RDID_WAIT;
      end
      ST_RDID_WAIT: begin
        if (w_done) w_next = (w_data == '0) ? ST_DONE : ST_RDSZ_REQ;
      end
      ST_RDSZ_REQ: begin
        w_start = 1'b1;
        w_addr  = DEVTBLADDR + w_k_word + 30'd1;
        if (w_acc) w_next = ST_RDSZ_WAIT;
      end
      ST_RDSZ_WAIT: begin
        if (w_done) begin
          if (r_cur_id == r_id || w_k_inc == KMAX) w_next = ST_DONE;
          else                                     w_next = ST_RDID_REQ;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Walk bookkeeping and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id       <= '0;
      r_cur_id   <= '0;
      r_base_acc <= '0;
      r_k        <= '0;
      r_found    <= 1'b0;
      r_base     <= '0;
      r_mapsz    <= '0;
      r_intr     <= 1'b0;
`ifdef DEVTBL_WALKER_VERSION_EN
      r_version  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (find_i) begin
            r_id       <= id_i;
            r_base_acc <= DEVSPACEBASE;
            r_k        <= '0;
            r_found    <= 1'b0;
            r_base     <= '0;
            r_mapsz    <= '0;
            r_intr     <= 1'b0;
          end
        end
`ifdef DEVTBL_WALKER_VERSION_EN
        ST_VER_WAIT:  if (w_done) r_version <= w_data;
`endif
        ST_RDID_WAIT: if (w_done) r_cur_id <= w_data;
        ST_RDSZ_WAIT: begin
          if (w_done) begin
            if (r_cur_id == r_id) begin
              r_found <= 1'b1;
              r_base  <= r_base_acc;
              r_mapsz <= w_data[ARCHBITSZ-1:2];
              r_intr  <= w_data[FLAG_INTR_BIT];
            end else begin
              r_base_acc <= r_base_acc + {w_data[ARCHBITSZ-1:2], 2'b00};
              r_k        <= w_k_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done_o  = (r_state == ST_DONE);
  assign found_o = r_found;
  assign base_o  = r_base;
  assign mapsz_o = r_mapsz;
  assign intr_o  = r_intr;

endmodule
